// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port imem between the IF fetch port and the loader/debug port.
// Define IMEM_ARB_PERF_EN to add perf_stall_cnt, a saturating count of stall cycles.
module imem_port_arbiter #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   output logic              stall,
   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef IMEM_ARB_PERF_EN
   ,
   output logic [15:0]       perf_stall_cnt
`endif
);

   localparam int unsigned LAT_W = 3;
   localparam int unsigned STV_W = 4;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t             state_q;
   state_t             state_d;
   logic [LAT_W-1:0]   lat_q;
   logic [STV_W-1:0]   starve_q;
   logic               owner_l_q;
   logic               owner_we_q;
   logic               fetch_win;
   logic               capture;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next state: one grant per IDLE visit, BUSY until the latency counter expires
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (f_req || l_req) state_d = BUSY;
         BUSY:    if (lat_q == '0)    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Grant and memory strobe; loader wins unless fetch has waited STARVE_MAX grants
   always_comb begin
      fetch_win = 1'b0;
      f_gnt     = 1'b0;
      l_gnt     = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      stall     = f_req & ~f_rvalid & ~reset;
      if (state_q == IDLE && !reset) begin
         fetch_win = f_req & (~l_req | (starve_q == STV_W'(STARVE_MAX)));
         f_gnt     = fetch_win;
         l_gnt     = l_req & ~fetch_win;
         mem_en    = f_gnt | l_gnt;
         mem_we    = l_gnt & l_we;
         if (l_gnt)      mem_addr = l_addr;
         else if (f_gnt) mem_addr = f_addr;
         if (l_gnt && l_we) mem_wdata = l_wdata;
      end
   end

   // Read data is on mem_rdata in the last counted cycle; rvalid lands the cycle after
   assign capture = (state_q == BUSY) && (lat_q == LAT_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_q      <= '0;
         owner_l_q  <= 1'b0;
         owner_we_q <= 1'b0;
         f_rvalid   <= 1'b0;
         l_rvalid   <= 1'b0;
         f_rdata    <= '0;
         l_rdata    <= '0;
      end else begin
         f_rvalid <= 1'b0;
         l_rvalid <= 1'b0;
         if (mem_en) begin
            owner_l_q  <= l_gnt;
            owner_we_q <= mem_we;
            lat_q      <= LAT_W'(MEM_LAT);
         end else if (state_q == BUSY && lat_q != '0) begin
            lat_q <= lat_q - LAT_W'(1);
         end
         if (capture) begin
            if (owner_l_q) begin
               l_rvalid <= 1'b1;
               l_rdata  <= owner_we_q ? '0 : mem_rdata;
            end else begin
               f_rvalid <= 1'b1;
               f_rdata  <= mem_rdata;
            end
         end
      end
   end

   // Consecutive loader grants taken while fetch is waiting
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                        starve_q <= '0;
      else if (!f_req || f_gnt)                         starve_q <= '0;
      else if (l_gnt && starve_q != STV_W'(STARVE_MAX)) starve_q <= starve_q + STV_W'(1);
   end

`ifdef IMEM_ARB_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               perf_stall_cnt <= '0;
      else if (stall && perf_stall_cnt != '1)  perf_stall_cnt <= perf_stall_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a transaction-level model (grant slot, delivery time, memory image).
module tb_imem_port_arbiter;

   localparam int unsigned ADDR_W     = 8;
   localparam int unsigned DATA_W     = 32;
   localparam int unsigned MEM_LAT    = 1;
   localparam int unsigned STARVE_MAX = 4;

   logic              clk;
   logic              reset;
   logic              f_req;
   logic [ADDR_W-1:0] f_addr;
   logic              f_gnt;
   logic              f_rvalid;
   logic [DATA_W-1:0] f_rdata;
   logic              stall;
   logic              l_req;
   logic              l_we;
   logic [ADDR_W-1:0] l_addr;
   logic [DATA_W-1:0] l_wdata;
   logic              l_gnt;
   logic              l_rvalid;
   logic [DATA_W-1:0] l_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
`ifdef IMEM_ARB_PERF_EN
   logic [15:0]       perf_stall_cnt;
`endif

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   imem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
      .f_rdata(f_rdata), .stall(stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_PERF_EN
      , .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_word(input int a);
      if (a == 0) return 32'h1234_5678;
      return (32'(a) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Memory device: read data valid for exactly one cycle, MEM_LAT cycles after mem_en
   logic [31:0] dmem [256];
   logic [31:0] dq   [MEM_LAT];
   logic        dv   [MEM_LAT];
   logic [31:0] junk;

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
      for (int i = 0; i < int'(MEM_LAT); i++) begin dv[i] = 1'b0; dq[i] = '0; end
      junk = 32'hBADC_0DE5;
      forever begin
         @(posedge clk);
         dv[0] <= mem_en && !mem_we;
         dq[0] <= dmem[mem_addr];
         for (int i = 1; i < int'(MEM_LAT); i++) begin
            dv[i] <= dv[i-1];
            dq[i] <= dq[i-1];
         end
         junk <= $urandom;
         if (mem_en && mem_we) dmem[mem_addr] = mem_wdata;
      end
   end

   assign mem_rdata = dv[MEM_LAT-1] ? dq[MEM_LAT-1] : junk;

   // Reference model: next free grant slot, one pending delivery, memory image
   initial begin
      logic [31:0] mm [256];
      int unsigned cyc, free_at, starve, pend_cyc;
      bit          pend, pend_l, can, e_fg, e_lg, e_fv, e_lv, e_we, e_stall;
      logic [31:0] pend_data, fr_exp, lr_exp;
      logic [7:0]  e_addr;
      int unsigned perf_exp;
      for (int i = 0; i < 256; i++) mm[i] = init_word(i);
      cyc = 0; free_at = 0; starve = 0; pend = 0; pend_l = 0; pend_cyc = 0;
      pend_data = '0; fr_exp = '0; lr_exp = '0; perf_exp = 0;
      forever begin
         @(negedge clk); #1;
`ifdef IMEM_ARB_PERF_EN
         chk("perf_stall_cnt", 32'(perf_stall_cnt), perf_exp);
`endif
         if (reset) begin
            chk("rst_f_gnt",    32'(f_gnt),    0);
            chk("rst_l_gnt",    32'(l_gnt),    0);
            chk("rst_f_rvalid", 32'(f_rvalid), 0);
            chk("rst_l_rvalid", 32'(l_rvalid), 0);
            chk("rst_f_rdata",  f_rdata,       0);
            chk("rst_l_rdata",  l_rdata,       0);
            chk("rst_stall",    32'(stall),    0);
            chk("rst_mem_en",   32'(mem_en),   0);
            pend = 0; starve = 0; fr_exp = '0; lr_exp = '0; free_at = cyc + 1; perf_exp = 0;
         end else begin
            e_fv = pend && !pend_l && pend_cyc == cyc;
            e_lv = pend &&  pend_l && pend_cyc == cyc;
            if (e_fv) fr_exp = pend_data;
            if (e_lv) lr_exp = pend_data;
            if (pend && pend_cyc == cyc) pend = 0;
            can  = cyc >= free_at;
            e_fg = can && f_req && (!l_req || starve == STARVE_MAX);
            e_lg = can && l_req && !e_fg;
            e_we = e_lg && l_we;
            e_addr  = e_lg ? l_addr : f_addr;
            e_stall = f_req && !e_fv;
            chk("f_gnt",    32'(f_gnt),    32'(e_fg));
            chk("l_gnt",    32'(l_gnt),    32'(e_lg));
            chk("mem_en",   32'(mem_en),   32'(e_fg || e_lg));
            chk("f_rvalid", 32'(f_rvalid), 32'(e_fv));
            chk("l_rvalid", 32'(l_rvalid), 32'(e_lv));
            chk("f_rdata",  f_rdata,       fr_exp);
            chk("l_rdata",  l_rdata,       lr_exp);
            chk("stall",    32'(stall),    32'(e_stall));
            if (e_fg || e_lg) begin
               chk("mem_we",   32'(mem_we),   32'(e_we));
               chk("mem_addr", 32'(mem_addr), 32'(e_addr));
               if (e_we) chk("mem_wdata", mem_wdata, l_wdata);
               pend      = 1;
               pend_l    = e_lg;
               pend_cyc  = cyc + MEM_LAT + 1;
               pend_data = e_we ? 32'h0 : mm[e_addr];
               if (e_we) mm[e_addr] = l_wdata;
               free_at   = cyc + MEM_LAT + 2;
            end
            if (!f_req || e_fg)                 starve = 0;
            else if (e_lg && starve < STARVE_MAX) starve++;
            if (e_stall && perf_exp < 32'hFFFF) perf_exp++;
         end
         cyc++;
      end
   end

   // Stimulus
   bit fg_seen, lg_seen;

   task automatic rand_cycle(input int unsigned dens);
      @(negedge clk);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 399) == 0) reset = 1'b1;
      if (!f_req || fg_seen) begin
         f_req  = ($urandom_range(0, 99) < dens);
         f_addr = 8'($urandom_range(0, 15));
      end else if ($urandom_range(0, 31) == 0) f_req = 1'b0;
      if (!l_req || lg_seen) begin
         l_req   = ($urandom_range(0, 99) < dens);
         l_we    = ($urandom_range(0, 2) == 0);
         l_addr  = 8'($urandom_range(0, 15));
         l_wdata = $urandom;
      end else if ($urandom_range(0, 31) == 0) l_req = 1'b0;
      #2;
      fg_seen = f_gnt;
      lg_seen = l_gnt;
   endtask

   initial begin
      int seq [$];
      int nwe, nfv;
      reset = 1'b1; f_req = 1'b0; f_addr = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      fg_seen = 0; lg_seen = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Fetch-only access to address 0
      @(negedge clk); f_req = 1'b1; f_addr = 8'd0; #1;
      chk("t1_f_gnt_t0", 32'(f_gnt), 1);
      chk("t1_mem_en_t0", 32'(mem_en), 1);
      chk("t1_stall_t0", 32'(stall), 1);
      @(negedge clk); #1;
      chk("t1_stall_t1", 32'(stall), 1);
      chk("t1_f_rvalid_t1", 32'(f_rvalid), 0);
      @(negedge clk); #1;
      chk("t1_f_rvalid_t2", 32'(f_rvalid), 1);
      chk("t1_f_rdata_t2", f_rdata, 32'h1234_5678);
      chk("t1_stall_t2", 32'(stall), 0);
      @(negedge clk); f_req = 1'b0;
      @(negedge clk);

      // Loader write then fetch of the same word
      nwe = 0;
      @(negedge clk); l_req = 1'b1; l_we = 1'b1; l_addr = 8'd5; l_wdata = 32'hDEAD_BEEF; #1;
      chk("t3_l_gnt", 32'(l_gnt), 1);
      chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      nwe += int'(mem_we);
      @(negedge clk); l_req = 1'b0; l_we = 1'b0; #1; nwe += int'(mem_we);
      @(negedge clk); #1; nwe += int'(mem_we);
      chk("t3_l_rvalid", 32'(l_rvalid), 1);
      chk("t3_l_rdata", l_rdata, 0);
      @(negedge clk); f_req = 1'b1; f_addr = 8'd5; #1; nwe += int'(mem_we);
      chk("t3_f_gnt", 32'(f_gnt), 1);
      @(negedge clk); f_req = 1'b0; #1; nwe += int'(mem_we);
      @(negedge clk); #1;
      chk("t3_f_rvalid", 32'(f_rvalid), 1);
      chk("t3_f_rdata", f_rdata, 32'hDEAD_BEEF);
      chk("t3_mem_we_count", 32'(nwe), 1);
      @(negedge clk);

      // Both held continuously: 4 loader grants, then fetch, repeating
      for (int c = 0; c < 30; c++) begin
         @(negedge clk); f_req = 1'b1; l_req = 1'b1; l_we = 1'b0;
         l_addr = 8'($urandom_range(0, 15)); f_addr = 8'($urandom_range(0, 15)); #1;
         if (l_gnt) seq.push_back(0);
         if (f_gnt) seq.push_back(1);
         chk("t4_rvalid_excl", 32'(f_rvalid & l_rvalid), 0);
      end
      @(negedge clk); f_req = 1'b0; l_req = 1'b0;
      chk("t4_grant_count", 32'(seq.size()), 10);
      foreach (seq[k]) chk("t4_grant_order", 32'(seq[k]), (k % 5 == 4) ? 1 : 0);
      repeat (2) @(negedge clk);

      // Reset one cycle after a fetch grant
      @(negedge clk); f_req = 1'b1; f_addr = 8'd3; #1;
      chk("t5_f_gnt", 32'(f_gnt), 1);
      @(negedge clk); reset = 1'b1; #1;
      chk("t5_stall_rst", 32'(stall), 0);
      chk("t5_mem_en_rst", 32'(mem_en), 0);
      @(negedge clk); f_req = 1'b0;
      @(negedge clk); reset = 1'b0;
      nfv = 0;
      repeat (4) begin @(negedge clk); #1; nfv += int'(f_rvalid); end
      chk("t5_no_f_rvalid", 32'(nfv), 0);
      @(negedge clk); f_req = 1'b1; f_addr = 8'd7; #1;
      chk("t5_f_gnt_after", 32'(f_gnt), 1);
      @(negedge clk); f_req = 1'b0;
      @(negedge clk); #1;
      chk("t5_f_rvalid_after", 32'(f_rvalid), 1);
      chk("t5_f_rdata_after", f_rdata, init_word(7));
      @(negedge clk);

      // Randomized traffic at three request densities
      fg_seen = 0; lg_seen = 0;
      repeat (1000) rand_cycle(30);
      repeat (1000) rand_cycle(70);
      repeat (1000) rand_cycle(100);
      @(negedge clk); reset = 1'b0; f_req = 1'b0; l_req = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
